// File: rtl/rotate_left_32_seq.sv
// Multi-cycle rotate-left unit. It handles one amount bit per clock, LSB first,
// so each step is a single conditional rotate by a power of two.
module rotate_left_32_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int STEP_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(AMT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   data_reg;
    logic [AMT_W-1:0]   amt_reg;
    logic [STEP_W-1:0]  step;
    logic [AMT_W-1:0]   shamt;
    logic [2*WIDTH-1:0] data_dbl;
    logic [WIDTH-1:0]   data_rot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)          state_next = SHIFT;
            SHIFT:   if (step == LAST_STEP) state_next = DONE;
            DONE:    if (out_ready)         state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Rotating by 2^step: shifting a doubled copy left and keeping the upper
    // half wraps the MSBs into the LSBs.
    always_comb begin
        shamt    = AMT_W'(1) << step;
        data_dbl = {data_reg, data_reg} << shamt;
        data_rot = data_dbl[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
            amt_reg  <= '0;
            step     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= a;
                        amt_reg  <= amt;
                        step     <= '0;
                    end
                end
                SHIFT: begin
                    if (amt_reg[step]) begin
                        data_reg <= data_rot;
                    end
                    step <= step + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign y         = data_reg;

endmodule

// File: tb/tb_rotate_left_32_seq.sv
// Scoreboard bench for rotate_left_32_seq: expected results are queued at accept
// time and compared against y, plus latency, when each result is handed off.
module tb_rotate_left_32_seq;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] exp;
        int               acc;
    } txn_t;

    txn_t sb[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   cycle       = 0;
    bit   rand_ready_en = 1'b0;
    logic prev_ov = 1'b0;

    rotate_left_32_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [AMT_W-1:0] s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[(i + int'(s)) % WIDTH] = x[i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input logic [AMT_W-1:0] s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = x[(i + int'(s)) % WIDTH];
        return r;
    endfunction

    // Output monitor: latency on each rising out_valid, data on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) checkOutput("spurious out_valid", {31'b0, out_valid}, 32'd0);
                else checkOutput("latency", 32'(cycle - sb[0].acc), 32'd5);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious result", {31'b0, out_valid}, 32'd0);
                end else begin
                    txn_t t;
                    t = sb.pop_front();
                    checkOutput("y", y, t.exp);
                    checkOutput("rotr(y)", rotr(y, t.amt), t.a);
                end
            end
        end
        prev_ov = out_valid;
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [AMT_W-1:0] amtv);
        bit accepted;
        accepted = 1'b0;
        @(negedge clk);
        a        = av;
        amt      = amtv;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            if (in_ready) begin
                @(posedge clk);
                accepted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!accepted) begin
            checkOutput("accept timeout", {31'b0, accepted}, 32'd1);
        end else begin
            #1;
            in_valid = 1'b0;
            sb.push_back('{av, amtv, rotl(av, amtv), cycle});
        end
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && !(sb.size() == 0 && in_ready); i++) @(negedge clk);
        if (!(sb.size() == 0 && in_ready)) checkOutput("drain timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        amt       = '0;
        out_ready = 1'b0;

        @(negedge clk);
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset y", y, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;

        // Single operation, then in_ready returns one cycle after the handoff.
        applyStimulus(32'h8000_0001, 5'd1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        checkOutput("single out_valid seen", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("single out_valid drop", {31'b0, out_valid}, 32'd0);
        checkOutput("single in_ready back", {31'b0, in_ready}, 32'd1);

        applyStimulus(32'h1234_5678, 5'd4);
        applyStimulus(32'h0000_0001, 5'd31);
        applyStimulus(32'hDEAD_BEEF, 5'd0);
        waitDrain(100);

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(32'h0000_F00F, 5'd16);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp y", y, 32'hF00F_0000);
            checkOutput("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp out_valid drop", {31'b0, out_valid}, 32'd0);
        checkOutput("bp in_ready back", {31'b0, in_ready}, 32'd1);

        // Operand capture: inputs change right after accept, second request waits.
        applyStimulus(32'h0000_0001, 5'd8);
        @(negedge clk);
        a        = 32'hFFFF_FFFF;
        amt      = 5'd3;
        in_valid = 1'b1;
        applyStimulus(32'hFFFF_FFFF, 5'd3);
        waitDrain(100);

        // Reset during SHIFT step 2: everything clears without a clock edge.
        @(negedge clk);
        a        = 32'hCAFE_BABE;
        amt      = 5'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("busy before reset", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midreset y", y, 32'd0);
        checkOutput("midreset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midreset busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("no stale result", {31'b0, out_valid}, 32'd0);

        // Random back-to-back traffic with random out_ready.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            applyStimulus($urandom, 5'($urandom_range(0, 31)));
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        waitDrain(200);
        checkOutput("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/rotate_left_32_seq.md
Name: rotate_left_32_seq

Overview:
Multi-cycle rotate-left unit, the left-direction counterpart of the 32-bit combinational rotate-right. It uses a log-step iterative datapath: one amount bit per clock, LSB first, so each step is a single conditional rotate instead of a full barrel network. It has valid/ready handshakes on input and output, and sits in the multifunction shifter as the area-lean rotate-left path.

Parameters:
WIDTH, 32, data width in bits.
AMT_W, 5, rotate-amount width; must equal clog2(WIDTH); also the number of iteration steps.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request carries valid a/amt
in_ready  output  1  block can accept a request
a  input  WIDTH  operand
amt  input  AMT_W  rotate-left amount, 0..WIDTH-1
out_valid  output  1  y holds a completed result
out_ready  input  1  consumer accepts result
y  output  WIDTH  rotated result, registered
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, data_reg=0, amt_reg=0, step=0, y=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid is high at a clock edge: data_reg<=a, amt_reg<=amt, step<=0, go to SHIFT.
  - If in_valid is low: stay in IDLE.
- SHIFT:
  - in_ready=0.
  - Each edge: if amt_reg[step]==1, data_reg<=data_reg rotated left by 2^step (MSBs wrap into LSBs, no bits lost); else data_reg holds.
  - step<=step+1.
  - At the edge where step==AMT_W-1, go to DONE.
- DONE:
  - out_valid=1, y=data_reg.
  - y and out_valid hold stable while out_ready is low (no timeout).
  - On the edge with out_ready high, go to IDLE and clear out_valid.
- Handshake and throughput:
  - in_ready is low in SHIFT and DONE. No new request is taken in the same cycle a result completes.
  - Next accept is possible on the first IDLE cycle after the output handshake.
- Latency:
  - Acceptance edge E sets state=SHIFT.
  - out_valid rises after edge E+AMT_W (5 cycles for the defaults).
  - With out_ready held high, one operation completes every AMT_W+2 cycles (7 for the defaults).
- Fixed latency: amt=0 still takes AMT_W steps; no fast path. The result then equals a.
- Arithmetic: the result is exactly {a[WIDTH-1-amt:0], a[WIDTH-1:WIDTH-amt]} for amt≠0, and a for amt=0. For all a and amt, rotate_right(result, amt) == a.
- Input changes after acceptance: a/amt changes after the accept edge have no effect. The operands are captured.
- in_valid during SHIFT/DONE: ignored. The request stays pending on the input side and is accepted in the next IDLE.
- y between operations: y holds data_reg. It holds the last result, or a partial value during SHIFT, and is meaningful only when out_valid=1.
- Reset mid-operation: reset in any state immediately returns all registers to their reset values. The operation is lost and no out_valid is produced for it.
- busy = (state != IDLE).

Test Plan:
- Single op: a=0x80000001, amt=1, out_ready=1 -> out_valid rises 5 cycles after accept, y=0x00000003, then in_ready=1 on the next cycle.
- Amounts: a=0x12345678, amt=4 -> y=0x23456781; a=0x00000001, amt=31 -> y=0x80000000; a=0xDEADBEEF, amt=0 -> y=0xDEADBEEF, still 5-cycle latency.
- Backpressure: complete a=0x0000F00F, amt=16 with out_ready=0 for 10 cycles -> y=0xF00F0000 and out_valid=1 held stable, in_ready=0 throughout. Raise out_ready -> out_valid drops after 1 edge.
- Operand capture: after accepting a=0x00000001, amt=8, drive a=0xFFFFFFFF, amt=3 and keep in_valid=1 -> first result y=0x00000100. The second request is accepted in the next IDLE and gives y=0xFFFFFFFF.
- Reset mid-op: assert reset asynchronously during SHIFT step 2 -> y=0, out_valid=0, busy=0, in_ready=1 with no clock edge. No stale result appears after release.
- Randomised: 1000 random a/amt pairs, back-to-back with random out_ready -> each y matches the reference rotl model, and feeding y/amt into rotate_right_32 returns the original a.
